// File: rtl/csr_reader.sv
// csr_reader: captures a packed CSR bundle on in_valid and streams its entries over valid/ready.
// Optional CSR_READER_BOUNDS_CHECK_EN skips out-of-range coordinates and raises bounds_err.
module csr_reader #(
    parameter int unsigned col_length         = 8,
    parameter int unsigned word_length        = 8,
    parameter int unsigned double_word_length = 16,
    parameter int unsigned image_size         = 28
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    input  logic [image_size*image_size*word_length-1:0] data_in,
    input  logic [image_size*image_size*col_length-1:0]  cols_in,
    input  logic [image_size*image_size*col_length-1:0]  rows_in,
    input  logic [double_word_length-1:0]                valid_num_in,
    output logic [word_length-1:0]                       out_value,
    output logic [col_length-1:0]                        out_col,
    output logic [col_length-1:0]                        out_row,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         out_last,
    output logic                                         done,
`ifdef CSR_READER_BOUNDS_CHECK_EN
    output logic                                         bounds_err,
`endif
    output logic                                         busy
);

    localparam int unsigned Entries   = image_size * image_size;
    localparam int unsigned DataW     = Entries * word_length;
    localparam int unsigned CoordW    = Entries * col_length;
    localparam int unsigned SlotW     = $clog2(Entries);
    localparam int unsigned DataOffW  = $clog2(DataW);
    localparam int unsigned CoordOffW = $clog2(CoordW);
    localparam logic [double_word_length-1:0] MaxCount = double_word_length'(Entries);

    typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;

    state_e                        state_q, state_d;
    logic [double_word_length-1:0] idx_q, idx_d, count_q, count_d;
    logic [DataW-1:0]              data_q, data_d;
    logic [CoordW-1:0]             cols_q, cols_d, rows_q, rows_d;
    logic [word_length-1:0]        out_value_q, out_value_d;
    logic [col_length-1:0]         out_col_q, out_col_d, out_row_q, out_row_d;
    logic                          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                          done_q, done_d, busy_q, busy_d, pulsed_q, pulsed_d;

    logic                          xfer;
    logic [double_word_length-1:0] step_idx;
    logic [SlotW-1:0]              slot;
    logic [DataOffW-1:0]           val_off;
    logic [CoordOffW-1:0]          crd_off;
    logic [word_length-1:0]        cand_value;
    logic [col_length-1:0]         cand_col, cand_row;
    logic                          cand_ok, cand_last;

    // The output register holds entry[idx_q]; step_idx is the entry due next after this cycle.
    assign xfer       = out_valid_q & out_ready;
    assign step_idx   = xfer ? idx_q + 1'b1 : idx_q;
    assign slot       = step_idx[SlotW-1:0];
    assign val_off    = DataOffW'(slot) * DataOffW'(word_length);
    assign crd_off    = CoordOffW'(slot) * CoordOffW'(col_length);
    assign cand_value = data_q[val_off +: word_length];
    assign cand_col   = cols_q[crd_off +: col_length];
    assign cand_row   = rows_q[crd_off +: col_length];

`ifdef CSR_READER_BOUNDS_CHECK_EN
    logic               err_q, err_d;
    logic [Entries-1:0] in_bounds;

    always_comb begin
        for (int j = 0; j < Entries; j++) begin
            in_bounds[j] = (cols_q[j*col_length +: col_length] < col_length'(image_size)) &&
                           (rows_q[j*col_length +: col_length] < col_length'(image_size));
        end
    end

    // Last means no later in-bounds entry remains below count.
    always_comb begin
        cand_last = 1'b1;
        for (int j = 0; j < Entries; j++) begin
            if (j > int'(step_idx) && j < int'(count_q) && in_bounds[j]) cand_last = 1'b0;
        end
    end

    assign cand_ok    = in_bounds[slot];
    assign bounds_err = err_q;
`else
    assign cand_ok   = 1'b1;
    assign cand_last = (step_idx == count_q - 1'b1);
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        data_d      = data_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        out_value_d = out_value_q;
        out_col_d   = out_col_q;
        out_row_d   = out_row_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        pulsed_d    = pulsed_q;
`ifdef CSR_READER_BOUNDS_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d   = data_in;
                    cols_d   = cols_in;
                    rows_d   = rows_in;
                    count_d  = (valid_num_in > MaxCount) ? MaxCount : valid_num_in;
                    pulsed_d = 1'b0;
`ifdef CSR_READER_BOUNDS_CHECK_EN
                    err_d    = 1'b0;
`endif
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                idx_d   = '0;
                state_d = (count_q == '0) ? StDrain : StStream;
            end
            StStream: begin
                idx_d = step_idx;
                if (xfer && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = StDrain;
                end else if (!out_valid_q || xfer) begin
                    if (step_idx >= count_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = StDrain;
                    end else if (cand_ok) begin
                        out_valid_d = 1'b1;
                        out_value_d = cand_value;
                        out_col_d   = cand_col;
                        out_row_d   = cand_row;
                        out_last_d  = cand_last;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        idx_d       = step_idx + 1'b1;
`ifdef CSR_READER_BOUNDS_CHECK_EN
                        err_d       = 1'b1;
`endif
                    end
                end
            end
            StDrain: begin
                // Pulse done once, then hold until the bundle's in_valid level is released.
                done_d   = !pulsed_q;
                pulsed_d = 1'b1;
                if (pulsed_q && !in_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            count_q     <= '0;
            data_q      <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            out_value_q <= '0;
            out_col_q   <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            pulsed_q    <= 1'b0;
`ifdef CSR_READER_BOUNDS_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            data_q      <= data_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            out_value_q <= out_value_d;
            out_col_q   <= out_col_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            pulsed_q    <= pulsed_d;
`ifdef CSR_READER_BOUNDS_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign out_value = out_value_q;
    assign out_col   = out_col_q;
    assign out_row   = out_row_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_csr_reader.sv
// tb_csr_reader: randomized bundles against a queue-based model; a monitor pops and compares
// every presented entry, while directed cases cover latency, saturation, stalls and reset abort.
module tb_csr_reader;

    localparam int N = 784;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [N*8-1:0] data_in = '0;
    logic [N*8-1:0] cols_in = '0;
    logic [N*8-1:0] rows_in = '0;
    logic [15:0]    valid_num_in = '0;
    logic [7:0]     out_value, out_col, out_row;
    logic           out_valid, out_last, done, busy;
`ifdef CSR_READER_BOUNDS_CHECK_EN
    logic           bounds_err;
`endif

    csr_reader dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .cols_in      (cols_in),
        .rows_in      (rows_in),
        .valid_num_in (valid_num_in),
        .out_value    (out_value),
        .out_col      (out_col),
        .out_row      (out_row),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .done         (done),
`ifdef CSR_READER_BOUNDS_CHECK_EN
        .bounds_err   (bounds_err),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] v;
        logic [7:0] c;
        logic [7:0] r;
        logic       last;
    } ent_t;

    ent_t       exp_q[$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         xfer_cnt = 0;
    int         done_seen = 0;
    int         done_target = 0;
    int         ready_mode = 0;
    bit         hold_prev = 1'b0;
    logic [7:0] vals[N];
    logic [7:0] cols[N];
    logic [7:0] rows[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            vals[i] = 8'($urandom_range(1, 255));
`ifdef CSR_READER_BOUNDS_CHECK_EN
            cols[i] = 8'($urandom_range(0, 27));
            rows[i] = 8'($urandom_range(0, 27));
`else
            cols[i] = 8'($urandom_range(0, 255));
            rows[i] = 8'($urandom_range(0, 255));
`endif
        end
    endtask

    // Model: the first min(n, 784) slots in order (in-bounds only when checking), last on final.
    task automatic start_bundle(input int n_req, input bit hold, output int n_exp);
        ent_t e;
        int   lim;
        lim   = (n_req > N) ? N : n_req;
        n_exp = 0;
        for (int i = 0; i < lim; i++) begin
`ifdef CSR_READER_BOUNDS_CHECK_EN
            if (cols[i] >= 8'd28 || rows[i] >= 8'd28) continue;
`endif
            e = '{v: vals[i], c: cols[i], r: rows[i], last: 1'b0};
            exp_q.push_back(e);
            n_exp++;
        end
        if (n_exp > 0) begin
            e      = exp_q.pop_back();
            e.last = 1'b1;
            exp_q.push_back(e);
        end
        xfer_cnt = 0;
        done_target++;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            data_in[i*8 +: 8] = vals[i];
            cols_in[i*8 +: 8] = cols[i];
            rows_in[i*8 +: 8] = rows[i];
        end
        valid_num_in = 16'(n_req);
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        // The bundle is already captured; later input changes must not leak in.
        data_in      = ~data_in;
        cols_in      = ~cols_in;
        rows_in      = ~rows_in;
        valid_num_in = 16'hffff;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic finish_bundle(input int n_exp, input bit hold);
        for (int i = 0; i < 4000 && done_seen < done_target; i++) @(posedge clk);
        check("done_pulse", 64'(done_seen), 64'(done_target));
        check("transfers", 64'(xfer_cnt), 64'(n_exp));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        if (hold) begin
            repeat (4) @(negedge clk);
            check("drain_waits_busy", 64'(busy), 64'd1);
            check("drain_no_retrigger", 64'(done_seen), 64'(done_target));
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("back_to_idle", 64'(busy), 64'd0);
        exp_q.delete();
    endtask

    // Cycle window for ready held high; k counts negedges after the LOAD edge.
    task automatic observe(input int n);
        logic [15:0] gv, gl, gd, gb, wv, wl, wd, wb;
        int          dd;
        dd = (n == 0) ? 2 : n + 3;
        gv = '0; gl = '0; gd = '0; gb = '0; wv = '0; wl = '0; wd = '0; wb = '0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            gv[k] = out_valid;
            gl[k] = out_last;
            gd[k] = done;
            gb[k] = busy;
            wv[k] = (n > 0) && (k >= 2) && (k <= n + 1);
            wl[k] = (n > 0) && (k == n + 1);
            wd[k] = (k == dd);
            wb[k] = (k <= dd);
        end
        check("valid_window", 64'(gv), 64'(wv));
        check("last_window", 64'(gl), 64'(wl));
        check("done_window", 64'(gd), 64'(wd));
        check("busy_window", 64'(gb), 64'(wb));
    endtask

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    out_ready = (ph == 0);
                    ph = (ph + 1) % 3;
                end
            endcase
        end
    end

    initial begin
        ent_t got;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) check("valid_held", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("entry_expected", 64'(exp_q.size()), 64'd1);
                    end else begin
                        got = '{v: out_value, c: out_col, r: out_row, last: out_last};
                        check("entry", 64'(got), 64'(exp_q[0]));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            xfer_cnt++;
                        end
                    end
                end
                hold_prev = out_valid && !out_ready;
                if (done) done_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        int ne;
        int nr;
        bit h;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {out_valid, out_last, done, busy, out_value, out_col, out_row}, '0);
`ifdef CSR_READER_BOUNDS_CHECK_EN
        check("reset_bounds_err", 64'(bounds_err), 64'd0);
`endif
        rst = 1'b0;

        fill_random();
        vals[0] = 8'd5; cols[0] = 8'd2;  rows[0] = 8'd0;
        vals[1] = 8'd9; cols[1] = 8'd27; rows[1] = 8'd1;
        vals[2] = 8'd1; cols[2] = 8'd0;  rows[2] = 8'd27;
        ready_mode = 0;
        start_bundle(3, 1'b0, ne);
        observe(3);
        finish_bundle(ne, 1'b0);

        fill_random();
        start_bundle(0, 1'b0, ne);
        observe(0);
        finish_bundle(ne, 1'b0);

        fill_random();
        ready_mode = 2;
        start_bundle(4, 1'b0, ne);
        finish_bundle(ne, 1'b0);

        fill_random();
        ready_mode = 1;
        start_bundle(1000, 1'b0, ne);
        finish_bundle(ne, 1'b0);
`ifndef CSR_READER_BOUNDS_CHECK_EN
        check("saturated_count", 64'(ne), 64'd784);
`endif

        fill_random();
        ready_mode = 0;
        start_bundle(2, 1'b1, ne);
        finish_bundle(ne, 1'b1);

        // Abort mid-stream with an asynchronous reset, then a fresh bundle.
        fill_random();
        start_bundle(5, 1'b0, ne);
        for (int i = 0; i < 50 && xfer_cnt < 2; i++) @(posedge clk);
        check("two_before_reset", 64'(xfer_cnt), 64'd2);
        #3 rst = 1'b1;
        #1;
        check("async_reset", {out_valid, out_last, done, busy, out_value, out_col, out_row}, '0);
        exp_q.delete();
        done_target--;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("no_done_on_abort", 64'(done_seen), 64'(done_target));
        fill_random();
        start_bundle(2, 1'b0, ne);
        finish_bundle(ne, 1'b0);

        for (int b = 0; b < 20; b++) begin
            fill_random();
            ready_mode = $urandom_range(0, 2);
            nr = $urandom_range(0, 12);
            h  = 1'($urandom_range(0, 1));
            start_bundle(nr, h, ne);
            finish_bundle(ne, h);
        end

`ifdef CSR_READER_BOUNDS_CHECK_EN
        fill_random();
        cols[1]    = 8'd30;
        ready_mode = 0;
        start_bundle(3, 1'b0, ne);
        finish_bundle(ne, 1'b0);
        check("bounds_skip_count", 64'(ne), 64'd2);
        check("bounds_err_set", 64'(bounds_err), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
